// File: rtl/pifo_pkg.sv
// rtl/pifo_pkg.sv - shared encodings and task-word layout for the PIFO task arbiter
package pifo_pkg;

  typedef enum logic [1:0] {
    RPU_IDLE = 2'b00,
    RPU_PUSH = 2'b01,
    RPU_POP  = 2'b10,
    RPU_WAIT = 2'b11
  } rpu_state_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_GRANT = 2'b01,
    ARB_HOLD  = 2'b10
  } arb_state_e;

  // Task word, MSB first: {op (1 = push), tree_id, payload}
  localparam int PAYLOAD_LSB = 0;

  function automatic int tree_lsb(input int ptw);
    return ptw;
  endfunction

  function automatic int op_bit(input int ptw, input int tree_bits);
    return ptw + tree_bits;
  endfunction

endpackage

// File: rtl/pifo_rr_pick.sv
// rtl/pifo_rr_pick.sv - combinational round-robin pick: first requester at or after ptr
module pifo_rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);

  logic found;

  // N is a power of two, so the W-bit sum wraps modulo N on its own
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[ptr + W'(i)]) begin
        found               = 1'b1;
        idx                 = ptr + W'(i);
        gnt[ptr + W'(i)]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pifo_task_arbiter.sv
// rtl/pifo_task_arbiter.sv - round-robin dispatch of task FIFO heads to PIFO root RPUs
// Define PIFO_ARB_STATS_EN to add per-RPU issue counters and a saturating conflict counter.
module pifo_task_arbiter
  import pifo_pkg::*;
#(
  parameter int PTW           = 16,
  parameter int LEVEL         = 4,
  parameter int TREE_NUM      = 4,
  parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
  parameter int ISSUE_GAP     = 2
) (
  input  logic                                   i_clk,
  input  logic                                   i_arst_n,
  input  logic [LEVEL*(PTW+TREE_NUM_BITS+1)-1:0] i_fifo_data,
  input  logic [LEVEL-1:0]                       i_fifo_empty,
  input  logic [2*LEVEL-1:0]                     i_rpu_state_nxt,
  output logic [LEVEL-1:0]                       o_fifo_pop,
  output logic [LEVEL-1:0]                       o_rpu_push,
  output logic [LEVEL-1:0]                       o_rpu_pop,
  output logic [LEVEL*TREE_NUM_BITS-1:0]         o_rpu_tree_id,
  output logic [LEVEL*PTW-1:0]                   o_rpu_push_data
`ifdef PIFO_ARB_STATS_EN
  ,
  output logic [LEVEL*32-1:0]                    o_issue_cnt,
  output logic [31:0]                            o_conflict_cnt
`endif
);

  localparam int TW  = PTW + TREE_NUM_BITS + 1;
  localparam int LW  = $clog2(LEVEL);
  localparam int OPB = op_bit(PTW, TREE_NUM_BITS);
  localparam int TRL = tree_lsb(PTW);
  localparam int HW  = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;

  logic [LW-1:0]                 target [LEVEL];
  logic [LEVEL-1:0][LEVEL-1:0]   req;
  logic [LEVEL-1:0][LEVEL-1:0]   gnt;
  logic [LEVEL-1:0][LW-1:0]      win;
  logic [LEVEL-1:0]              decide;

  // LEVEL is a power of two, so truncating the tree id gives tree_id mod LEVEL
  for (genvar q = 0; q < LEVEL; q++) begin : g_fifo
    assign target[q] = LW'(i_fifo_data[q*TW+TRL +: TREE_NUM_BITS]);
  end

  for (genvar r = 0; r < LEVEL; r++) begin : g_rpu
    arb_state_e          state;
    arb_state_e          state_next;
    logic [HW-1:0]       hold_cnt;
    logic [LW-1:0]       rr_ptr;
    logic [TW-1:0]       task_q;
    logic                push_o;
    logic                pop_o;
    logic [TREE_NUM_BITS-1:0] tid_o;
    logic [PTW-1:0]      data_o;

    for (genvar q = 0; q < LEVEL; q++) begin : g_req
      assign req[r][q] = !i_fifo_empty[q] && (target[q] == LW'(r));
    end

    assign decide[r] = (state == ARB_IDLE) && (i_rpu_state_nxt[2*r +: 2] == RPU_IDLE) && (|req[r]);

    pifo_rr_pick #(.N(LEVEL)) u_pick (
      .req (req[r]),
      .ptr (rr_ptr),
      .gnt (gnt[r]),
      .idx (win[r])
    );

    always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) state <= ARB_IDLE;
      else           state <= state_next;
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
        hold_cnt <= '0;
        rr_ptr   <= '0;
        task_q   <= '0;
      end else begin
        if (decide[r]) begin
          task_q <= i_fifo_data[win[r]*TW +: TW];
          rr_ptr <= win[r] + 1'b1;
        end
        if (state == ARB_GRANT)     hold_cnt <= HW'(ISSUE_GAP - 1);
        else if (state == ARB_HOLD) hold_cnt <= hold_cnt - 1'b1;
      end
    end

    // Leaving HOLD as the count reaches zero keeps the rate at one task per ISSUE_GAP+1 cycles
    always_comb begin
      state_next = state;
      case (state)
        ARB_IDLE:  if (decide[r]) state_next = ARB_GRANT;
        ARB_GRANT: state_next = (ISSUE_GAP == 1) ? ARB_IDLE : ARB_HOLD;
        ARB_HOLD:  if (hold_cnt <= HW'(1)) state_next = ARB_IDLE;
        default:   state_next = ARB_IDLE;
      endcase
    end

    always_comb begin
      push_o = 1'b0;
      pop_o  = 1'b0;
      tid_o  = '0;
      data_o = '1;
      if (state == ARB_GRANT) begin
        push_o = task_q[OPB];
        pop_o  = !task_q[OPB];
        tid_o  = task_q[TRL +: TREE_NUM_BITS];
        if (task_q[OPB]) data_o = task_q[PAYLOAD_LSB +: PTW];
      end
    end

    assign o_rpu_push[r]                                   = push_o;
    assign o_rpu_pop[r]                                    = pop_o;
    assign o_rpu_tree_id[r*TREE_NUM_BITS +: TREE_NUM_BITS] = tid_o;
    assign o_rpu_push_data[r*PTW +: PTW]                   = data_o;
  end

  always_comb begin
    o_fifo_pop = '0;
    for (int r = 0; r < LEVEL; r++) begin
      if (decide[r]) o_fifo_pop = o_fifo_pop | gnt[r];
    end
    if (!i_arst_n) o_fifo_pop = '0;
  end

`ifdef PIFO_ARB_STATS_EN
  logic [LEVEL*32-1:0] issue_cnt;
  logic [31:0]         conflict_cnt;
  logic [31:0]         losers;
  logic [32:0]         conflict_sum;

  always_comb begin
    losers = '0;
    for (int r = 0; r < LEVEL; r++) begin
      if (decide[r]) losers = losers + 32'($countones(req[r])) - 32'd1;
    end
  end

  assign conflict_sum = {1'b0, conflict_cnt} + {1'b0, losers};

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      issue_cnt    <= '0;
      conflict_cnt <= '0;
    end else begin
      for (int r = 0; r < LEVEL; r++) begin
        issue_cnt[r*32 +: 32] <= issue_cnt[r*32 +: 32] + 32'(o_rpu_push[r] | o_rpu_pop[r]);
      end
      conflict_cnt <= conflict_sum[32] ? '1 : conflict_sum[31:0];
    end
  end

  assign o_issue_cnt    = issue_cnt;
  assign o_conflict_cnt = conflict_cnt;
`endif

endmodule

// File: tb/tb_pifo_task_arbiter.sv
// tb/tb_pifo_task_arbiter.sv - directed and randomized checks of pifo_task_arbiter against a queue model
module tb_pifo_task_arbiter;

  localparam int PTW       = 16;
  localparam int LEVEL     = 4;
  localparam int TREE_NUM  = 4;
  localparam int TNB       = 2;
  localparam int ISSUE_GAP = 2;
  localparam int TW        = PTW + TNB + 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [LEVEL*TW-1:0]    fifo_data = '0;
  logic [LEVEL-1:0]       fifo_empty = '1;
  logic [2*LEVEL-1:0]     rpu_state_nxt = '0;
  logic [LEVEL-1:0]       fifo_pop, rpu_push, rpu_pop;
  logic [LEVEL*TNB-1:0]   rpu_tid;
  logic [LEVEL*PTW-1:0]   rpu_data;
`ifdef PIFO_ARB_STATS_EN
  logic [LEVEL*32-1:0]    issue_cnt;
  logic [31:0]            conflict_cnt;
`endif

  always #5 clk = ~clk;

  pifo_task_arbiter #(
    .PTW(PTW), .LEVEL(LEVEL), .TREE_NUM(TREE_NUM), .TREE_NUM_BITS(TNB), .ISSUE_GAP(ISSUE_GAP)
  ) dut (
    .i_clk           (clk),
    .i_arst_n        (rst_n),
    .i_fifo_data     (fifo_data),
    .i_fifo_empty    (fifo_empty),
    .i_rpu_state_nxt (rpu_state_nxt),
    .o_fifo_pop      (fifo_pop),
    .o_rpu_push      (rpu_push),
    .o_rpu_pop       (rpu_pop),
    .o_rpu_tree_id   (rpu_tid),
    .o_rpu_push_data (rpu_data)
`ifdef PIFO_ARB_STATS_EN
    ,
    .o_issue_cnt     (issue_cnt),
    .o_conflict_cnt  (conflict_cnt)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Bench-side show-ahead FIFOs and reference state
  logic [TW-1:0] fq [LEVEL][$];
  int            ready [LEVEL];
  int            ptr [LEVEL];
  int            issued [LEVEL];
  int            conflicts = 0;
  int            cyc = 0;

  logic [LEVEL-1:0]     exp_pop;
  logic [LEVEL-1:0]     ex_push = '0, ex_pop = '0, nx_push, nx_pop;
  logic [LEVEL*TNB-1:0] ex_tid = '0, nx_tid;
  logic [LEVEL*PTW-1:0] ex_data = '1, nx_data;

  logic [LEVEL-1:0]     obs_pop, obs_push, obs_rpop;
  logic [LEVEL*TNB-1:0] obs_tid;
  logic [LEVEL*PTW-1:0] obs_data;
  logic [LEVEL-1:0]     pop_hist [9];
  logic [LEVEL-1:0]     push_hist [9];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [TW-1:0] mk(input bit op, input int tid, input int pl);
    logic [PTW-1:0] p;
    p = op ? PTW'(pl) : '0;
    return {op, TNB'(tid), p};
  endfunction

  task automatic drive();
    for (int q = 0; q < LEVEL; q++) begin
      fifo_empty[q] = (fq[q].size() == 0);
      if (fq[q].size() == 0) fifo_data[q*TW +: TW] = TW'($urandom);
      else                   fifo_data[q*TW +: TW] = fq[q][0];
    end
  endtask

  // An RPU may decide again ISSUE_GAP+1 cycles after its last decision
  task automatic model_eval();
    exp_pop = '0;
    nx_push = '0; nx_pop = '0; nx_tid = '0; nx_data = '1;
    if (!rst_n) begin
      ex_push = '0; ex_pop = '0; ex_tid = '0; ex_data = '1;
      conflicts = 0;
      for (int r = 0; r < LEVEL; r++) begin
        ready[r] = 0; ptr[r] = 0; issued[r] = 0;
      end
      return;
    end
    for (int r = 0; r < LEVEL; r++) begin
      int cnt;
      int winq;
      logic [TW-1:0] h;
      cnt = 0;
      winq = -1;
      if (cyc < ready[r] || rpu_state_nxt[2*r +: 2] != 2'b00) continue;
      for (int k = 0; k < LEVEL; k++) begin
        int q;
        q = (ptr[r] + k) % LEVEL;
        if (fq[q].size() > 0) begin
          h = fq[q][0];
          if (int'(h[PTW +: TNB]) % LEVEL == r) begin
            cnt++;
            if (winq < 0) winq = q;
          end
        end
      end
      if (winq >= 0) begin
        h = fq[winq][0];
        exp_pop[winq] = 1'b1;
        ptr[r]   = (winq + 1) % LEVEL;
        ready[r] = cyc + ISSUE_GAP + 1;
        conflicts += cnt - 1;
        issued[r]++;
        nx_push[r] = h[TW-1];
        nx_pop[r]  = !h[TW-1];
        nx_tid[r*TNB +: TNB] = h[PTW +: TNB];
        if (h[TW-1]) nx_data[r*PTW +: PTW] = h[PTW-1:0];
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_eval();
    obs_pop = fifo_pop; obs_push = rpu_push; obs_rpop = rpu_pop; obs_tid = rpu_tid; obs_data = rpu_data;
    chk("fifo_pop",      64'(fifo_pop), 64'(exp_pop));
    chk("rpu_push",      64'(rpu_push), 64'(ex_push));
    chk("rpu_pop",       64'(rpu_pop),  64'(ex_pop));
    chk("rpu_tree_id",   64'(rpu_tid),  64'(ex_tid));
    chk("rpu_push_data", 64'(rpu_data), 64'(ex_data));
    @(posedge clk);
    #1;
    for (int q = 0; q < LEVEL; q++) begin
      if (exp_pop[q] && fq[q].size() > 0) fq[q].delete(0);
    end
    ex_push = nx_push; ex_pop = nx_pop; ex_tid = nx_tid; ex_data = nx_data;
    cyc++;
    drive();
  endtask

  initial begin
    int left;
    // Reset state, with a pending head that must not be popped
    fq[0].push_back(mk(1'b1, 2, 16'h1234));
    drive();
    step();
    step();
    chk("rst_pop",  64'(obs_pop),  64'h0);
    chk("rst_data", 64'(obs_data), 64'hFFFF_FFFF_FFFF_FFFF);
    rst_n = 1'b1;

    // Single push, tree 2 from FIFO 0
    step();
    chk("t1_pop", 64'(obs_pop), 64'h1);
    step();
    chk("t1_push", 64'(obs_push), 64'h4);
    chk("t1_tid",  64'(obs_tid),  64'h20);
    chk("t1_data", 64'(obs_data), 64'hFFFF_1234_FFFF_FFFF);
    step();

    // Three FIFOs contend for RPU 1
    fq[0].push_back(mk(1'b1, 1, 16'hA001));
    fq[1].push_back(mk(1'b1, 1, 16'hA002));
    fq[3].push_back(mk(1'b1, 1, 16'hA003));
    drive();
    for (int i = 0; i < 9; i++) begin
      step();
      pop_hist[i]  = obs_pop;
      push_hist[i] = obs_push;
    end
    chk("t2_pop0",  64'(pop_hist[0]),  64'h1);
    chk("t2_pop1",  64'(pop_hist[1]),  64'h0);
    chk("t2_pop3",  64'(pop_hist[3]),  64'h2);
    chk("t2_pop6",  64'(pop_hist[6]),  64'h8);
    chk("t2_push1", 64'(push_hist[1]), 64'h2);
    chk("t2_push4", 64'(push_hist[4]), 64'h2);
    chk("t2_push7", 64'(push_hist[7]), 64'h2);

    // Pop for tree 3 held off by a busy RPU
    fq[2].push_back(mk(1'b0, 3, 0));
    rpu_state_nxt[7:6] = 2'b01;
    drive();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_wait", 64'(obs_pop), 64'h0);
    end
    rpu_state_nxt[7:6] = 2'b00;
    step();
    chk("t3_pop", 64'(obs_pop), 64'h4);
    step();
    chk("t3_rpop", 64'(obs_rpop), 64'h8);
    chk("t3_tid",  64'(obs_tid),  64'hC0);
    chk("t3_data", 64'(obs_data), 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    step();

    // Disjoint requests issue on all RPUs together
    for (int q = 0; q < LEVEL; q++) fq[q].push_back(mk(1'b1, q, 16'hB000 + q));
    drive();
    step();
    chk("t4_pop", 64'(obs_pop), 64'hF);
    step();
    chk("t4_push", 64'(obs_push), 64'hF);
    step();
    step();

    // Reset during the GRANT cycle
    fq[1].push_back(mk(1'b1, 0, 16'hC001));
    fq[3].push_back(mk(1'b1, 0, 16'hC003));
    drive();
    step();
    chk("t5_pop", 64'(obs_pop), 64'h2);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_push", 64'(rpu_push), 64'h0);
    chk("t5_rst_data", 64'(rpu_data), 64'hFFFF_FFFF_FFFF_FFFF);
    fq[0].push_back(mk(1'b1, 0, 16'hC000));
    drive();
    step();
    rst_n = 1'b1;
    step();
    chk("t5_first", 64'(obs_pop), 64'h1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int q = 0; q < LEVEL; q++) begin
        if (fq[q].size() < 4 && $urandom_range(0, 2) == 0)
          fq[q].push_back(mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom)));
      end
      for (int r = 0; r < LEVEL; r++)
        rpu_state_nxt[2*r +: 2] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      drive();
      step();
    end

    rpu_state_nxt = '0;
    drive();
    for (int i = 0; i < 200; i++) begin
      left = 0;
      for (int q = 0; q < LEVEL; q++) left += fq[q].size();
      if (left == 0) break;
      step();
    end
    chk("drain", 64'(left), 64'h0);
    for (int i = 0; i < 5; i++) step();

`ifdef PIFO_ARB_STATS_EN
    for (int r = 0; r < LEVEL; r++) chk("issue_cnt", 64'(issue_cnt[r*32 +: 32]), 64'(issued[r]));
    chk("conflict_cnt", 64'(conflict_cnt), 64'(conflicts));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pifo_task_arbiter.md
# pifo_task_arbiter

Dispatches queued push/pop tasks from the per-level task FIFOs to the root RPUs of the PIFO SRAM tree. Each task's root RPU is `tree_id mod LEVEL`. The block round-robin arbitrates among FIFO heads that target the same RPU. It issues only to RPUs whose next state is idle and that are outside their post-issue hold-off window. It sits between the task FIFOs and the RPU push/pop/tree-id inputs of the PIFO tree top level.

## Interface
- PTW, 16, payload width
- LEVEL, 4, number of RPUs, SRAMs and task FIFOs; power of two, at least 2
- TREE_NUM, 4, number of logical trees
- TREE_NUM_BITS, $clog2(TREE_NUM), tree id width
- ISSUE_GAP, 2, minimum cycles between issues to the same RPU; at least 1
- i_clk  in  1  clock
- i_arst_n  in  1  asynchronous active-low reset
- i_fifo_data  in  [PTW+TREE_NUM_BITS:0] x LEVEL  FIFO head, show-ahead
  - bit layout, MSB first: {op (1 = push, 0 = pop), tree_id, payload}
- i_fifo_empty  in  LEVEL  per-FIFO empty flag
- i_rpu_state_nxt  in  [1:0] x LEVEL  RPU next state; 2'b00 means idle
- o_fifo_pop  out  LEVEL  pop strobe, one cycle per grant
- o_rpu_push  out  LEVEL  push strobe to RPU
- o_rpu_pop  out  LEVEL  pop strobe to RPU
- o_rpu_tree_id  out  [TREE_NUM_BITS-1:0] x LEVEL  tree id of the issued task
- o_rpu_push_data  out  [PTW-1:0] x LEVEL  payload of the issued task

## Operation
- Request: FIFO q requests RPU r = i_fifo_data[q].tree_id & (LEVEL-1) when !i_fifo_empty[q] and q has no grant outstanding this cycle.
- Each RPU r runs its own FSM:
  - IDLE → GRANT: at least one request targets r and i_rpu_state_nxt[r] == 2'b00.
  - GRANT (one cycle): registers the winning head and pulses o_rpu_push[r] or o_rpu_pop[r] from the op bit. Then → HOLD with hold_cnt = ISSUE_GAP-1, or → IDLE if ISSUE_GAP == 1.
  - HOLD: hold_cnt decrements each cycle; at 0 → IDLE.
- Arbitration: per-RPU rr_ptr[r] of $clog2(LEVEL) bits. Winner is the first requester at or after rr_ptr[r], wrapping modulo LEVEL. On grant, rr_ptr[r] ← winner + 1, modulo LEVEL.
- A FIFO head targets exactly one RPU, so no FIFO can be granted by two RPUs in the same cycle.
- o_fifo_pop[q] is combinational and asserts in the grant-decision cycle (IDLE with idle RPU and valid request).
- o_rpu_* outputs are registered.
- Non-issuing RPUs drive o_rpu_push = o_rpu_pop = 0, o_rpu_tree_id = 0 and o_rpu_push_data = all ones.
- Payload is passed through unmodified. Pop tasks carry payload 0 but drive all ones on o_rpu_push_data.
- Reset (asynchronous, any time): all FSMs → IDLE, rr_ptr = 0, hold_cnt = 0, o_rpu_push = 0, o_rpu_pop = 0, o_rpu_tree_id = 0, o_rpu_push_data = all ones. The combinational o_fifo_pop is 0 while in reset. An in-flight issue is dropped; the task already popped is lost, and this is documented behaviour.

## Timing
- Cycle t: request valid, RPU idle, FSM in IDLE → o_fifo_pop[q] = 1.
- Cycle t+1: o_rpu_push or o_rpu_pop[r] = 1, carrying the head sampled at t.
- Sustained rate per RPU: one task per ISSUE_GAP+1 cycles. With ISSUE_GAP = 1 the next grant decision is at t+2.
- All LEVEL RPUs can issue in the same cycle when their requests are disjoint.
- If i_rpu_state_nxt[r] != 0, requests wait. No o_fifo_pop is issued and the head stays intact.
- If the empty flag rises in the same cycle as an RPU becoming idle, there is no grant.

## Configuration
- PIFO_ARB_STATS_EN defined adds outputs:
  - o_issue_cnt [31:0] x LEVEL: per-RPU issued-task counters, wrap at 2^32.
  - o_conflict_cnt [31:0]: increments by the number of losing requesters in each grant cycle, saturates at all ones.
  - Both counters reset to 0.
- Without the macro these ports and counters do not exist, and arbitration behaviour is identical.

## Structure
- Shared package pifo_pkg holds:
  - the rpu_state_e encoding (IDLE = 2'b00),
  - the task-word field offsets (op bit, tree_id, payload),
  - the arb_state_e enum (IDLE, GRANT, HOLD).
- One sub-module, pifo_rr_pick: LEVEL-bit request vector plus pointer in, one-hot grant and index out; purely combinational. Instantiate it once per RPU.

## Test plan
- Single push, tree 2, FIFO 0, data 0x1234, RPU 2 idle → o_fifo_pop = 4'b0001 at t; o_rpu_push[2] = 1, tree_id 2, data 0x1234 at t+1.
- FIFOs 0, 1, 3 all hold tree-1 pushes, ISSUE_GAP = 2 → RPU 1 issues from FIFO 0, then 1, then 3, at t+1, t+4, t+7; o_fifo_pop pulses at t, t+3, t+6.
- Pop for tree 3 while i_rpu_state_nxt[3] = 2'b01 for 5 cycles → no o_fifo_pop for those 5 cycles; o_rpu_pop[3] pulses 2 cycles after state returns to 00.
- Four FIFOs target trees 0–3 simultaneously → o_fifo_pop = 4'hF in one cycle; all four RPUs issue in the next cycle.
- i_arst_n asserted in the GRANT cycle → outputs at reset values immediately; rr_ptr = 0 after release; first grant goes to the lowest-index requester.
- With PIFO_ARB_STATS_EN, three FIFOs contending for RPU 0 → o_conflict_cnt = 2 after the first grant, 3 after the second; o_issue_cnt[0] = 3 at the end.
